mem_port_arbiter: RTL and testbench

//   Shares the single memory port between the CPU's instruction-fetch requester (I, read-only)
//   and its load/store requester (D). Sits between the mips core and the unified memory model.

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/arb_loss_cnt.sv | 30 +++
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state encodings, owner selects and sizing helper for the memory port arbiter
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // Width of a counter that must be able to hold the value max_wait
  function automatic int cnt_width(input int max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/arb_loss_cnt.sv
// rtl/arb_loss_cnt.sv - saturating count of consecutive fetch arbitration losses
module arb_loss_cnt
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int CW       = cnt_width(MAX_WAIT)
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [CW-1:0] cnt;

  // clear has priority; increments stop once the limit is reached
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign sat = (cnt >= CW'(MAX_WAIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single memory port shared by fetch (I) and load/store (D), data first with fetch anti-starvation
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata
);

  arb_state_t state, state_nxt;
  logic       win_owner;
  logic       gnt_i, gnt_d;
  logic       ack_i, ack_d;
  logic       loss_inc, loss_clr, loss_sat;

  arb_loss_cnt #(.MAX_WAIT(MAX_WAIT)) u_loss_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (loss_inc),
    .clr   (loss_clr),
    .sat   (loss_sat)
  );

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // arbitration in IDLE, completion detection in BUSY; requests are ignored while busy
  always_comb begin
    state_nxt = state;
    win_owner = OWN_D;
    gnt_i     = 1'b0;
    gnt_d     = 1'b0;
    ack_i     = 1'b0;
    ack_d     = 1'b0;
    loss_inc  = 1'b0;
    loss_clr  = 1'b0;
    case (state)
      IDLE: begin
        win_owner = (d_req && !(i_req && loss_sat)) ? OWN_D : OWN_I;
        if (win_owner == OWN_D && d_req) begin
          gnt_d     = 1'b1;
          state_nxt = BUSY_D;
        end else if (i_req) begin
          gnt_i     = 1'b1;
          state_nxt = BUSY_I;
        end
        loss_inc = gnt_d && i_req;
        loss_clr = gnt_i || !i_req;
      end
      BUSY_I: begin
        if (mem_ack) begin
          ack_i     = 1'b1;
          state_nxt = IDLE;
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          ack_d     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // registered grant/response pulses and the memory-side fields of the owning request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_gnt     <= 1'b0;
      d_gnt     <= 1'b0;
      i_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      i_gnt    <= gnt_i;
      d_gnt    <= gnt_d;
      i_rvalid <= ack_i;
      d_rvalid <= ack_d;
      if (gnt_i) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= i_addr;
        mem_be   <= '1;
      end else if (gnt_d) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        mem_be    <= d_be;
      end else if (ack_i || ack_d) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end
      if (ack_i) begin
        i_rdata <= mem_rdata;
      end
      // a completed write leaves the previous load data in place
      if (ack_d && !mem_we) begin
        d_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk, reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  mem_port_arbiter #(.AW(32), .DW(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {
    int          cyc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } gexp_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } rexp_t;

  gexp_t q_gi[$], q_gd[$];
  rexp_t q_ri[$], q_rd[$];
  logic [31:0] mem_m [logic [31:0]];

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // transaction-level view of the shared port
  bit          m_busy, m_own_d, m_we;
  logic [31:0] m_addr, m_wdata, last_d;
  logic [3:0]  m_be;
  int          m_wait, loss;
  bit          gi_prev, gd_prev;

  initial clk = 1'b1;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return a ^ 32'h5a5a_0f0f;
  endfunction

  task automatic mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] v;
    v = mem_rd(a);
    for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = d[8*b +: 8];
    mem_m[a] = v;
  endtask

  task automatic new_i();
    i_req  = 1'b1;
    i_addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
  endtask

  task automatic new_d();
    d_req   = 1'b1;
    d_we    = 1'($urandom_range(0, 1));
    d_addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
    d_wdata = $urandom;
    d_be    = 4'($urandom_range(1, 15));
  endtask

  // one cycle of stimulus, issued at the falling edge, plus the expected consequences of the next rising edge
  task automatic step(input int p_i, input int p_d, input int keep_pct, input bit allow_ack);
    gexp_t g;
    rexp_t r;
    if (gi_prev) begin
      if (int'($urandom_range(0, 99)) < keep_pct) new_i(); else i_req = 1'b0;
    end else if (!i_req && int'($urandom_range(0, 99)) < p_i) new_i();
    if (gd_prev) begin
      if (int'($urandom_range(0, 99)) < keep_pct) new_d(); else d_req = 1'b0;
    end else if (!d_req && int'($urandom_range(0, 99)) < p_d) new_d();
    gi_prev = 1'b0;
    gd_prev = 1'b0;

    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (m_busy) begin
      if (m_wait == 0 && allow_ack) begin
        mem_ack = 1'b1;
        if (!(m_own_d && m_we)) mem_rdata = mem_rd(m_addr);
      end else if (m_wait > 0) m_wait--;
    end else if (allow_ack) begin
      mem_ack = ($urandom_range(0, 7) == 0);
    end

    if (!m_busy) begin
      // data wins unless fetch has already lost MAX_WAIT times in a row while waiting
      if (d_req && !(i_req && loss >= MAX_WAIT)) begin
        loss    = i_req ? ((loss < MAX_WAIT) ? loss + 1 : loss) : 0;
        m_busy  = 1'b1;
        m_own_d = 1'b1;
        m_we    = d_we;
        m_addr  = d_addr;
        m_wdata = d_wdata;
        m_be    = d_be;
        m_wait  = $urandom_range(0, 3);
        gd_prev = 1'b1;
        g = '{cyc + 1, d_we, d_addr, d_wdata, d_be};
        q_gd.push_back(g);
      end else if (i_req) begin
        loss    = 0;
        m_busy  = 1'b1;
        m_own_d = 1'b0;
        m_we    = 1'b0;
        m_addr  = i_addr;
        m_be    = 4'hf;
        m_wait  = $urandom_range(0, 3);
        gi_prev = 1'b1;
        g = '{cyc + 1, 1'b0, i_addr, 32'h0, 4'hf};
        q_gi.push_back(g);
      end else begin
        loss = 0;
      end
    end else if (mem_ack) begin
      m_busy = 1'b0;
      if (!m_own_d) begin
        r = '{cyc + 1, mem_rdata};
        q_ri.push_back(r);
      end else if (m_we) begin
        mem_wr(m_addr, m_wdata, m_be);
        r = '{cyc + 1, last_d};
        q_rd.push_back(r);
      end else begin
        last_d = mem_rdata;
        r = '{cyc + 1, mem_rdata};
        q_rd.push_back(r);
      end
    end
  endtask

  // monitor: pops expectations whenever the DUT presents a grant or response, or when one was due
  initial begin
    bit e;
    forever begin
      @(posedge clk);
      #2;
      if (!reset) begin
        e = (q_gi.size() > 0 && q_gi[0].cyc == cyc);
        if (i_gnt || e) begin
          chk("i_gnt", 32'(i_gnt), 32'(e));
          if (e && i_gnt) begin
            chk("i_mem_req", 32'(mem_req), 32'd1);
            chk("i_mem_we", 32'(mem_we), 32'd0);
            chk("i_mem_addr", mem_addr, q_gi[0].addr);
            chk("i_mem_be", 32'(mem_be), 32'hf);
          end
          if (e) void'(q_gi.pop_front());
        end
        e = (q_gd.size() > 0 && q_gd[0].cyc == cyc);
        if (d_gnt || e) begin
          chk("d_gnt", 32'(d_gnt), 32'(e));
          if (e && d_gnt) begin
            chk("d_mem_req", 32'(mem_req), 32'd1);
            chk("d_mem_we", 32'(mem_we), 32'(q_gd[0].we));
            chk("d_mem_addr", mem_addr, q_gd[0].addr);
            chk("d_mem_wdata", mem_wdata, q_gd[0].wdata);
            chk("d_mem_be", 32'(mem_be), 32'(q_gd[0].be));
          end
          if (e) void'(q_gd.pop_front());
        end
        e = (q_ri.size() > 0 && q_ri[0].cyc == cyc);
        if (i_rvalid || e) begin
          chk("i_rvalid", 32'(i_rvalid), 32'(e));
          if (e && i_rvalid) begin
            chk("i_rdata", i_rdata, q_ri[0].data);
            chk("i_done_mem_req", 32'(mem_req), 32'd0);
          end
          if (e) void'(q_ri.pop_front());
        end
        e = (q_rd.size() > 0 && q_rd[0].cyc == cyc);
        if (d_rvalid || e) begin
          chk("d_rvalid", 32'(d_rvalid), 32'(e));
          if (e && d_rvalid) begin
            chk("d_rdata", d_rdata, q_rd[0].data);
            chk("d_done_mem_req", 32'(mem_req), 32'd0);
          end
          if (e) void'(q_rd.pop_front());
        end
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while ((m_busy || i_req || d_req || gi_prev || gd_prev) && n < 200) begin
      @(negedge clk);
      step(0, 0, 0, 1'b1);
      n++;
    end
    chk("drain_timeout", 32'(n >= 200), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // driver: reset, random traffic phases, mid-transaction reset, recovery
  initial begin
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    mem_ack = 0; mem_rdata = 0;
    m_busy = 0; m_own_d = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_be = 0;
    m_wait = 0; loss = 0; last_d = 0; gi_prev = 0; gd_prev = 0;
    reset = 1'b1;
    #5 reset = 1'b0;
    #1;
    chk("reset_ctrl", 32'({i_gnt, i_rvalid, d_gnt, d_rvalid, mem_req, mem_we, mem_be}), 32'd0);
    chk("reset_i_rdata", i_rdata, 32'd0);
    chk("reset_d_rdata", d_rdata, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);

    repeat (1200) begin @(negedge clk); step(40, 40, 50, 1'b1); end
    repeat (300)  begin @(negedge clk); step(100, 100, 100, 1'b1); end
    repeat (600)  begin @(negedge clk); step(15, 15, 30, 1'b1); end
    drain();

    // abort a data read in flight
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_wdata = 32'h0; d_be = 4'hf;
    step(0, 0, 0, 1'b0);
    @(negedge clk);
    step(0, 0, 0, 1'b0);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("abort_mem_req", 32'(mem_req), 32'd0);
    chk("abort_pulses", 32'({i_gnt, d_gnt, i_rvalid, d_rvalid}), 32'd0);
    m_busy = 0; loss = 0; last_d = 0; gi_prev = 0; gd_prev = 0;
    q_gi.delete(); q_gd.delete(); q_ri.delete(); q_rd.delete();
    @(negedge clk);
    reset = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = $urandom;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("post_abort_quiet", 32'({i_gnt, d_gnt, i_rvalid, d_rvalid, mem_req}), 32'd0);
    end
    @(negedge clk);
    mem_ack = 1'b0;

    repeat (300) begin @(negedge clk); step(50, 50, 60, 1'b1); end
    drain();

    chk("left_i_gnt", 32'(q_gi.size()), 32'd0);
    chk("left_d_gnt", 32'(q_gd.size()), 32'd0);
    chk("left_i_rsp", 32'(q_ri.size()), 32'd0);
    chk("left_d_rsp", 32'(q_rd.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
